// File: rtl/rsa_pkg.sv
// Shared RSA constants and the modexp/handshake state encoding used by the
// encoder and decoder blocks.
package rsa_pkg;

    localparam int RSA_W = 16;
    localparam int RSA_N = 3551;
    localparam int RSA_E = 5;
    localparam int RSA_D = 1373;
    localparam int RSA_T = 3432;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        STEP_A,
        STEP_B,
        OUT,
        HOLD
    } state_t;

endpackage

// File: rtl/rsa_modexp_core.sv
// Right-to-left square-and-multiply: operand^EXP mod N, one exponent bit per
// STEP_A/STEP_B pair. done is high for the single OUT cycle.
import rsa_pkg::*;

module rsa_modexp_core #(
    parameter int W   = RSA_W,
    parameter int N   = RSA_N,
    parameter int EXP = RSA_D
) (
    input  logic         clk,
    input  logic         res,
    input  logic         start,
    input  logic [W-1:0] operand,
    output logic         done,
    output logic [W-1:0] result,
    output state_t       state
);

    localparam logic [W-1:0]   MOD  = W'(N);
    localparam logic [2*W-1:0] MOD2 = (2*W)'(N);

    state_t         state_nx;
    logic [W-1:0]   base;
    logic [W-1:0]   e_reg;
    logic [2*W-1:0] prod_r;
    logic [2*W-1:0] prod_b;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state  <= IDLE;
            base   <= '0;
            result <= '0;
            e_reg  <= '0;
            prod_r <= '0;
            prod_b <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        base   <= operand;
                        result <= W'(1);
                        e_reg  <= W'(EXP);
                    end
                end
                REDUCE: base <= base % MOD;
                STEP_A: begin
                    prod_r <= {{W{1'b0}}, result} * {{W{1'b0}}, base};
                    prod_b <= {{W{1'b0}}, base} * {{W{1'b0}}, base};
                end
                STEP_B: begin
                    // Both remainders are below N, so truncating to W bits is lossless.
                    if (e_reg[0]) result <= W'(prod_r % MOD2);
                    base  <= W'(prod_b % MOD2);
                    e_reg <= e_reg >> 1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REDUCE;
            REDUCE:  state_nx = (e_reg == '0) ? OUT : STEP_A;
            STEP_A:  state_nx = STEP_B;
            STEP_B:  state_nx = (e_reg[W-1:1] == '0) ? OUT : STEP_A;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign done = (state == OUT);

endmodule

// File: rtl/rsa_decoder.sv
// RSA decryption block: data_out = data_in^D mod N behind valid/ready
// handshakes, one transaction in flight.
import rsa_pkg::*;

module rsa_decoder #(
    parameter int W = RSA_W,
    parameter int N = RSA_N,
    parameter int D = RSA_D
) (
    input  logic         clk,
    input  logic         res,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out
);

    state_t       core_state;
    state_t       state;
    logic         start;
    logic         core_done;
    logic [W-1:0] core_result;

    rsa_modexp_core #(
        .W   (W),
        .N   (N),
        .EXP (D)
    ) u_core (
        .clk     (clk),
        .res     (res),
        .start   (start),
        .operand (data_in),
        .done    (core_done),
        .result  (core_result),
        .state   (core_state)
    );

    // The core idles while a finished word waits here; out_valid marks HOLD.
    assign state    = out_valid ? HOLD : core_state;
    assign in_ready = (state == IDLE);
    assign start    = in_valid & in_ready;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (core_done) begin
            out_valid <= 1'b1;
            data_out  <= core_result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
